// File: rtl/keypad_matrix_responder.sv
// keypad_matrix_responder: column-side model of a 4x4 membrane keypad.
// Tracks the contact state of 16 keys (press/release commands over a
// valid/ready handshake) and answers the scanner's active-low row drive
// with active-low column levels, with optional pseudo-random chatter.
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst           synchronous active-low reset
//   row[3:0]      scanner row drive, active-low, row[3-r] selects row r
//   col[3:0]      column return, active-low, col[3-c] for column c
//   cmd_valid     command present
//   cmd_ready     command can be accepted this cycle
//   cmd_key[3:0]  key index k = 4*r + c
//   cmd_press     1 = close contact, 0 = open contact
//   busy          bounce sequence in progress
//   pressed_mask  settled contact state, bit k = key k closed

module keypad_matrix_responder #(
    parameter int unsigned BOUNCE_CYCLES = 16,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic        cmd_press,
    output logic        busy,
    output logic [15:0] pressed_mask
);

    typedef enum logic {
        S_IDLE,
        S_BOUNCE
    } state_t;

    localparam bit NO_BOUNCE = (BOUNCE_CYCLES == 0);

    // Counter runs BOUNCE_CYCLES-1 .. 0, so the settle edge lands
    // exactly BOUNCE_CYCLES edges after acceptance.
    localparam logic [7:0] CNT_INIT =
        NO_BOUNCE ? 8'd0 : 8'(BOUNCE_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_n;
    logic        r_live;
    logic [3:0]  r_s1;
    logic [3:0]  r_s2;
    logic [3:0]  r_col;
    logic [15:0] r_contact;
    logic [15:0] r_mask;
    logic [3:0]  r_target;
    logic        r_dir;
    logic [7:0]  r_cnt;
    logic [7:0]  r_lfsr;

    logic [15:0] w_mask_n;
    logic [3:0]  w_target_n;
    logic        w_dir_n;
    logic [7:0]  w_cnt_n;
    logic        w_ready;
    logic        w_busy;
    logic [15:0] w_contact;
    logic [3:0]  w_col;
    logic        w_lfsr_fb;

    // Row synchronizer, contact register and column register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1      <= 4'hF;
            r_s2      <= 4'hF;
            r_contact <= 16'h0000;
            r_col     <= 4'hF;
        end else begin
            r_s1      <= row;
            r_s2      <= r_s1;
            r_contact <= w_contact;
            r_col     <= w_col;
        end
    end

    // Free-running chatter source, independent of the FSM.
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    // Only the target key chatters; every other key shows its
    // settled state.
    always_comb begin
        w_contact = r_mask;
        if (r_state == S_BOUNCE) begin
            w_contact[r_target] = r_lfsr[0];
        end
    end

    // Passive matrix: a column is pulled low by any closed key on
    // any selected row, so multiple selected rows ghost naturally.
    always_comb begin
        w_col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!r_s2[3-r] && r_contact[4*r+c]) begin
                    w_col[3-c] = 1'b0;
                end
            end
        end
    end

    // FSM state and command registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_live   <= 1'b0;
            r_mask   <= 16'h0000;
            r_target <= 4'd0;
            r_dir    <= 1'b0;
            r_cnt    <= 8'd0;
        end else begin
            r_state  <= w_state_n;
            r_live   <= 1'b1;
            r_mask   <= w_mask_n;
            r_target <= w_target_n;
            r_dir    <= w_dir_n;
            r_cnt    <= w_cnt_n;
        end
    end

    // r_live holds cmd_ready low for the first edge out of reset.
    always_comb begin
        w_state_n  = r_state;
        w_mask_n   = r_mask;
        w_target_n = r_target;
        w_dir_n    = r_dir;
        w_cnt_n    = r_cnt;
        w_ready    = 1'b0;
        w_busy     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready = r_live;
                if (cmd_valid && r_live) begin
                    w_target_n = cmd_key;
                    w_dir_n    = cmd_press;
                    if (NO_BOUNCE || (r_mask[cmd_key] == cmd_press)) begin
                        w_mask_n[cmd_key] = cmd_press;
                    end else begin
                        w_state_n = S_BOUNCE;
                        w_cnt_n   = CNT_INIT;
                    end
                end
            end
            S_BOUNCE: begin
                w_busy = 1'b1;
                if (r_cnt == 8'd0) begin
                    w_mask_n[r_target] = r_dir;
                    w_state_n          = S_IDLE;
                end else begin
                    w_cnt_n = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign col          = r_col;
    assign cmd_ready    = w_ready;
    assign busy         = w_busy;
    assign pressed_mask = r_mask;

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Bench for keypad_matrix_responder: two instances (no bounce and
// 16-cycle bounce) share one stimulus and are checked against a model.

module tb_keypad_matrix_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row = 4'h0;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_key = 4'd0;
    logic        cmd_press = 1'b0;

    logic [3:0]  col0, col1;
    logic        rdy0, rdy1;
    logic        busy0, busy1;
    logic [15:0] mask0, mask1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    keypad_matrix_responder #(
        .BOUNCE_CYCLES(0),
        .LFSR_SEED(8'hA5)
    ) u0 (
        .clk(clk), .rst(rst), .row(row), .col(col0),
        .cmd_valid(cmd_valid), .cmd_ready(rdy0),
        .cmd_key(cmd_key), .cmd_press(cmd_press),
        .busy(busy0), .pressed_mask(mask0)
    );

    keypad_matrix_responder #(
        .BOUNCE_CYCLES(16),
        .LFSR_SEED(8'hA5)
    ) u1 (
        .clk(clk), .rst(rst), .row(row), .col(col1),
        .cmd_valid(cmd_valid), .cmd_ready(rdy1),
        .cmd_key(cmd_key), .cmd_press(cmd_press),
        .busy(busy1), .pressed_mask(mask1)
    );

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expire(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Behavioural model: matrix read of a contact set.
    function automatic logic [3:0] colfn(input logic [3:0] rw,
                                         input logic [15:0] con);
        logic [3:0] c4;
        c4 = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (rw[3-r] == 1'b0 && con[4*r+c]) c4[3-c] = 1'b0;
        return c4;
    endfunction

    function automatic int bcyc(input int i);
        return (i == 0) ? 0 : 16;
    endfunction

    logic [15:0] m_mask [2];
    logic [15:0] m_con  [2];
    logic [3:0]  m_col  [2];
    logic        m_bnc  [2];
    int          m_rem  [2];
    logic [3:0]  m_tgt  [2];
    logic        m_dir  [2];
    logic [7:0]  m_lfsr [2];
    logic [15:0] m_nc;
    logic        m_live;
    logic [3:0]  m_ra, m_rb;
    bit          m_ok = 0;

    // Model: row seen two edges late, contacts one edge late, bounce
    // settles BOUNCE_CYCLES edges after acceptance.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_mask[i] = 16'h0; m_con[i] = 16'h0; m_col[i] = 4'hF;
                m_bnc[i] = 1'b0; m_rem[i] = 0; m_tgt[i] = 4'd0;
                m_dir[i] = 1'b0; m_lfsr[i] = 8'hA5;
            end
            m_live = 1'b0; m_ra = 4'hF; m_rb = 4'hF;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_col[i] = colfn(m_rb, m_con[i]);
                m_nc = m_mask[i];
                if (m_bnc[i]) m_nc[m_tgt[i]] = m_lfsr[i][0];
                m_con[i] = m_nc;
                if (m_live && !m_bnc[i] && cmd_valid) begin
                    if (bcyc(i) == 0 || m_mask[i][cmd_key] == cmd_press) begin
                        m_mask[i][cmd_key] = cmd_press;
                    end else begin
                        m_bnc[i] = 1'b1; m_rem[i] = bcyc(i);
                        m_tgt[i] = cmd_key; m_dir[i] = cmd_press;
                    end
                end else if (m_bnc[i]) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        m_mask[i][m_tgt[i]] = m_dir[i];
                        m_bnc[i] = 1'b0;
                    end
                end
                m_lfsr[i] = {m_lfsr[i][6:0], m_lfsr[i][7] ^ m_lfsr[i][5]
                             ^ m_lfsr[i][4] ^ m_lfsr[i][3]};
            end
            m_rb = m_ra; m_ra = row; m_live = 1'b1;
        end
        m_ok = 1;
    end

    always @(posedge clk) begin
        #1;
        if (m_ok) begin
            chk("col0", {12'h0, col0}, {12'h0, m_col[0]});
            chk("rdy0", {15'h0, rdy0}, {15'h0, m_live && !m_bnc[0]});
            chk("busy0", {15'h0, busy0}, {15'h0, m_bnc[0]});
            chk("mask0", mask0, m_mask[0]);
            chk("col1", {12'h0, col1}, {12'h0, m_col[1]});
            chk("rdy1", {15'h0, rdy1}, {15'h0, m_live && !m_bnc[1]});
            chk("busy1", {15'h0, busy1}, {15'h0, m_bnc[1]});
            chk("mask1", mask1, m_mask[1]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [3:0] k, input logic p);
        bit got;
        got = 0;
        cmd_valid = 1'b1; cmd_key = k; cmd_press = p;
        for (int n = 0; n < 100; n++) begin
            if (rdy1) begin got = 1; break; end
            @(negedge clk);
        end
        if (!got) expire("send");
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100; n++) begin
            if (rdy1 && !busy1) return;
            @(negedge clk);
        end
        expire("wait_idle");
    endtask

    initial begin
        // Reset with rows driven low and a command offered.
        rst = 1'b0; row = 4'h0;
        cmd_valid = 1'b1; cmd_key = 4'd3; cmd_press = 1'b1;
        cyc(3);
        chk("rst_col0", {12'h0, col0}, 16'h000F);
        chk("rst_col1", {12'h0, col1}, 16'h000F);
        chk("rst_mask1", mask1, 16'h0000);
        chk("rst_rdy1", {15'h0, rdy1}, 16'h0000);
        rst = 1'b1; cmd_valid = 1'b0; row = 4'hF;
        @(negedge clk);
        chk("post_rst_rdy0", {15'h0, rdy0}, 16'h0001);
        chk("post_rst_rdy1", {15'h0, rdy1}, 16'h0001);

        // No-bounce instance: key 6 on row 1 column 2.
        send(4'd6, 1'b1);
        row = 4'b1011;
        cyc(2);
        chk("b0_lat2", {12'h0, col0}, 16'h000F);
        cyc(1);
        chk("b0_lat3", {12'h0, col0}, 16'h000D);
        row = 4'b0111;
        cyc(3);
        chk("b0_row0", {12'h0, col0}, 16'h000F);
        wait_idle();
        send(4'd6, 1'b0);
        wait_idle();

        // Bounce: key 0 with a second command held behind it.
        send(4'd0, 1'b1);
        chk("b16_busy", {15'h0, busy1}, 16'h0001);
        chk("b16_nrdy", {15'h0, rdy1}, 16'h0000);
        cmd_valid = 1'b1; cmd_key = 4'd1; cmd_press = 1'b1;
        cyc(15);
        chk("b16_busy15", {15'h0, busy1}, 16'h0001);
        chk("b16_mask15", mask1, 16'h0000);
        cyc(1);
        chk("b16_mask16", mask1, 16'h0001);
        chk("b16_idle16", {15'h0, busy1}, 16'h0000);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b16_held", {15'h0, busy1}, 16'h0001);
        @(negedge clk);
        chk("b16_col", {12'h0, col1}, 16'h0007);
        wait_idle();

        // Ghosting across rows 0 and 1.
        send(4'd4, 1'b1);
        wait_idle();
        row = 4'b0011;
        cyc(3);
        chk("ghost0", {12'h0, col0}, 16'h0003);
        chk("ghost1", {12'h0, col1}, 16'h0003);
        send(4'd1, 1'b0);
        wait_idle();
        cyc(2);
        chk("ghost_rel0", {12'h0, col0}, 16'h0007);
        chk("ghost_rel1", {12'h0, col1}, 16'h0007);

        // No-op commands go back to back.
        send(4'd0, 1'b0); wait_idle();
        send(4'd4, 1'b0); wait_idle();
        send(4'd5, 1'b1); wait_idle();
        cmd_valid = 1'b1; cmd_key = 4'd5; cmd_press = 1'b1;
        chk("noop_rdy_a", {15'h0, rdy1}, 16'h0001);
        @(negedge clk);
        cmd_key = 4'd9; cmd_press = 1'b0;
        chk("noop_rdy_b", {15'h0, rdy1}, 16'h0001);
        chk("noop_busy_b", {15'h0, busy1}, 16'h0000);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("noop_busy_c", {15'h0, busy1}, 16'h0000);
        chk("noop_mask1", mask1, 16'h0020);
        chk("noop_mask0", mask0, 16'h0020);
        row = 4'hF;
        cyc(3);
        chk("row_idle", {12'h0, col1}, 16'h000F);

        // Reset in the middle of a bounce on key 15.
        row = 4'b1110;
        send(4'd15, 1'b1);
        cyc(4);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_mask", mask1, 16'h0000);
        chk("abort_busy", {15'h0, busy1}, 16'h0000);
        chk("abort_col", {12'h0, col1}, 16'h000F);
        cyc(1);
        rst = 1'b1;
        @(negedge clk);
        send(4'd15, 1'b1);
        wait_idle();
        cyc(3);
        chk("k15_col", {12'h0, col1}, 16'h000E);
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_responder.md
# keypad_matrix_responder

Column-side model of a 4x4 membrane keypad for the row-strobing keypad scanner. It accepts press/release commands over a valid/ready handshake and tracks the contact state of all 16 keys. It samples the scanner's active-low row drive and returns active-low column levels exactly as a passive switch matrix would, with optional pseudo-random contact bounce on each transition. It sits opposite the scanner in self-test builds and benches, either looped back on-chip or driven from switches/UART.

## Interface
- BOUNCE_CYCLES, 16: clock cycles of contact chatter after each state change; 0 disables bounce. Range 0..255.
- LFSR_SEED, 8'hA5: reset value of the bounce LFSR; must be nonzero.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-low.
- row  input  4  scanner row drive, active-low; row[3-r]==0 selects matrix row r.
- col  output  4  column return, active-low, idle 4'hF; col[3-c] pulled low by closed key (r,c) on a selected row.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command can be accepted this cycle.
- cmd_key  input  4  key index k = 4*r + c.
- cmd_press  input  1  1 = press (close), 0 = release (open).
- busy  output  1  bounce sequence in progress.
- pressed_mask  output  16  settled contact state; bit k = key k closed.

## Operation
- Reset (rst==0 at posedge): col=4'hF, pressed_mask=0, busy=0, cmd_ready=0, FSM=IDLE, row sync regs=4'hF, LFSR=LFSR_SEED, bounce counter=0. cmd_ready goes 1 on the first clock after rst returns high.
- Row input passes a 2-flop synchronizer (s1, s2) before use.
- Contact vector: contact[k] = pressed_mask[k], except during BOUNCE where contact[target] = lfsr[0].
- Column function: col_next[3-c] = 0 iff some r with s2[3-r]==0 and contact[4r+c]==1; else 1. Several rows low at once is legal: columns AND across all selected rows, reproducing real ghosting. row==4'hF gives col=4'hF.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts every cycle out of reset, independent of FSM.
- FSM states:
  - IDLE: cmd_ready=1, busy=0. On cmd_valid&cmd_ready: latch target=cmd_key, dir=cmd_press.
    - If pressed_mask[target]==dir, or BOUNCE_CYCLES==0: set pressed_mask[target]=dir (no-op when already equal) on the same edge; stay IDLE.
    - Otherwise: go to BOUNCE, counter=BOUNCE_CYCLES-1.
  - BOUNCE: cmd_ready=0, busy=1, counter decrements each cycle. When counter==0: pressed_mask[target]=dir, go to IDLE.
- Commands presented while cmd_ready==0 are not consumed; the requester holds cmd_valid/cmd_key/cmd_press stable until accepted.
- Only one key bounces at a time; other keys keep their settled state throughout.
- Reset asserted mid-BOUNCE aborts the sequence: all keys open, target transition discarded.

## Timing
- Row-to-col latency: 3 cycles (2 sync + 1 output register). A row change at edge N is reflected on col after edge N+3.
- Command acceptance edge A, bounce enabled: busy=1 and cmd_ready=0 from A+1 through A+BOUNCE_CYCLES; pressed_mask updates and busy drops at edge A+BOUNCE_CYCLES; next command acceptable at edge A+BOUNCE_CYCLES+1.
- No-op, or BOUNCE_CYCLES==0: pressed_mask updates at A; cmd_ready stays 1, giving back-to-back acceptance every cycle.
- Contact change visible on col (row held selected) at A+2, after the mask/contact register and the col register.

## Test plan
- Reset: hold rst=0 for 3 cycles with row=4'h0 and cmd_valid=1 -> col=4'hF, pressed_mask=0, cmd_ready=0, no command consumed; cmd_ready=1 one cycle after release.
- BOUNCE_CYCLES=0: press key 6 (r1,c2); drive row=4'b1011 -> col=4'b1101 exactly 3 cycles after row applied; row=4'b0111 -> col=4'hF.
- BOUNCE_CYCLES=16: press key 0 at edge A -> busy high A+1..A+16, cmd_ready low, second command held and not accepted; pressed_mask=16'h0001 at A+16; col on row 4'b0111 chatters per lfsr[0] then settles to 4'b0111.
- Ghosting: press keys 0, 1, 4; drive row=4'b0011 -> col=4'b0011; release key 1 -> col=4'b0111.
- No-op: press key 5 twice, release key 9 (already open) -> second and third commands accepted in consecutive cycles, busy never set, pressed_mask=16'h0020.
- Reset mid-bounce: press key 15, assert rst at A+5 -> pressed_mask=0, busy=0, col=4'hF; after release, LFSR restarts from LFSR_SEED.
